// File: rtl/ddr_burst_arbiter.sv
// Two-requester round-robin arbiter for one shared DDR burst channel.
// It issues one burst command at a time, counts data beats and aborts bursts that stall.
module ddr_burst_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [15:0]         req_len,
  output logic [1:0]          req_ready,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_wr,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [7:0]          cmd_len,
  input  logic                beat,
  output logic                busy,
  output logic                timeout,
  output logic                err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic              sel_s;
  logic              hs_s;

  // Requester selection; acceptance is held off in the cycle a burst ends
  always_comb begin
    sel_s = 1'b0;
    if (req_valid == 2'b10) begin
      sel_s = 1'b1;
    end else if (req_valid == 2'b11) begin
      sel_s = ~rr_last_q;
    end else begin
      sel_s = 1'b0;
    end
    req_ready = 2'b00;
    if (!user_rst && state_q == S_IDLE && done_q == 2'b00 && !timeout_q && req_valid != 2'b00) begin
      req_ready = sel_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign hs_s = |(req_valid & req_ready);

  // Next-state logic for the burst FSM, beat counter and watchdog
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    beat_cnt_d  = beat_cnt_q;
    wdog_d      = wdog_q;
    timeout_d   = 1'b0;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        err_d = err_q | beat;
        if (hs_s) begin
          cmd_wr_d    = req_wr[sel_s];
          cmd_addr_d  = sel_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          cmd_len_d   = sel_s ? req_len[15:8] : req_len[7:0];
          gnt_d       = sel_s ? 2'b10 : 2'b01;
          rr_last_d   = sel_s;
          cmd_valid_d = 1'b1;
          state_d     = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        err_d = err_q | beat;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          beat_cnt_d  = 8'd0;
          wdog_d      = '0;
          state_d     = S_DATA;
        end else begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        // A beat on the watchdog's terminal cycle still counts and rearms it
        if (beat) begin
          wdog_d = '0;
          if (beat_cnt_q == cmd_len_q) begin
            done_d  = gnt_q;
            gnt_d   = 2'b00;
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else if (wdog_q == WD_LAST) begin
          wdog_d    = '0;
          timeout_d = 1'b1;
          err_d     = 1'b1;
          gnt_d     = 2'b00;
          state_d   = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        gnt_d       = 2'b00;
        cmd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= 8'd0;
      beat_cnt_q  <= 8'd0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      beat_cnt_q  <= beat_cnt_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = (state_q != S_IDLE);
  assign timeout   = timeout_q;
  assign err       = err_q;

endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
- Two-requester round-robin arbiter sharing one DDR burst command/data channel behind the XDMA-DDR wrapper.
- Requester 0 is the XDMA-side mover; requester 1 is user logic.
- Accepts one burst request at a time, issues it downstream, grants data-path ownership, and counts beats to completion.
- A beat watchdog aborts stalled bursts.

Parameters:
- ADDR_W, 32, width of each burst byte address.
- TIMEOUT, 1024, idle cycles in DATA without a beat before abort (must be ≥2).

Ports:
- user_clk  in  1  single clock domain.
- user_rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester burst request, bit i = requester i.
- req_wr  in  2  1 = write burst, 0 = read burst.
- req_addr  in  2*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W].
- req_len  in  16  beats-1 per requester, requester i at bits [i*8 +: 8].
- req_ready  out  2  acceptance strobe; handshake when req_valid[i] & req_ready[i].
- gnt  out  2  one-hot data-path ownership, used as the data mux select.
- done  out  2  one-cycle pulse when requester i's burst completes normally.
- cmd_valid  out  1  downstream command valid.
- cmd_ready  in  1  downstream command accept.
- cmd_wr  out  1  latched direction.
- cmd_addr  out  ADDR_W  latched address.
- cmd_len  out  8  latched beats-1.
- beat  in  1  one pulse per completed data beat on the shared channel.
- busy  out  1  state != IDLE.
- timeout  out  1  one-cycle pulse on watchdog abort.
- err  out  1  sticky; set on abort or on a stray beat; cleared only by reset.

Behaviour:
- Reset (async, user_rst=1), applies immediately:
  - State = IDLE.
  - All outputs 0: gnt, done, cmd_*, req_ready, busy, timeout, err.
  - Beat and watchdog counters 0.
  - rr_last = 1, so requester 0 wins the first tie.
  - Reset mid-burst drops gnt and cmd_valid asynchronously; no done is issued.
- States: IDLE, CMD, DATA.
- IDLE:
  - req_ready is combinational: at most one bit is set, only in IDLE, only toward the selected requester.
  - Selection rule: if exactly one req_valid bit is set, select it. If both are set, select the requester != rr_last.
  - On handshake: latch wr/addr/len into the cmd_* registers, set gnt one-hot for the selected requester, set rr_last = selected, go to CMD.
- CMD:
  - cmd_valid = 1, with cmd_* stable until cmd_ready is sampled high.
  - Then go to DATA with beat count = 0 and watchdog = 0.
  - gnt is held throughout CMD.
- DATA:
  - Each beat increments the beat count.
  - When beat arrives with beat count == cmd_len: pulse done[sel] for one cycle, clear gnt, go to IDLE.
  - The next request can be accepted in the cycle after done, so there is one idle cycle between bursts.
  - cmd_len = 0 means a single-beat burst.
  - Beat count is 8 bits; the maximum of 256 beats never wraps because exit occurs at equality.
- Watchdog:
  - Active in DATA only.
  - Increments every cycle with beat=0 and resets to 0 on beat.
  - When it reaches TIMEOUT-1 with no beat: pulse timeout, set err, clear gnt, go to IDLE, issue no done.
  - CMD wait is not timed.
- Stray beat: beat in IDLE or CMD is ignored for counting and sets err.
- Simultaneous events: if beat and the watchdog terminal count coincide, the beat wins and the watchdog resets.
- Requirements on requesters (asserted in the bench): hold req_* stable while req_valid is high until the handshake; deasserting req_valid before the handshake is permitted.
- Latency: handshake → cmd_valid = 1 cycle; last beat → done pulse = 1 cycle (registered); done → next req_ready ≥ 1 cycle.

Test Plan:
- After reset, req_valid=2'b11, both len=3, cmd_ready=1, 4 beats per burst → requester 0 served first (done[0]), then requester 1 (done[1]); gnt goes 01 → 00 → 10; err=0.
- Continuous req_valid=2'b11 for 4 bursts → grant order 0,1,0,1; rr_last alternates.
- req_valid[1] only, len=0, addr=0x1000_0040, wr=1, cmd_ready held low 5 cycles → cmd_valid high with cmd_addr=0x1000_0040 and cmd_wr=1 stable for 5 cycles; one beat → done[1] pulse.
- TIMEOUT=16, len=7, only 3 beats then silence → timeout pulses 16 cycles after the last beat; gnt cleared; no done; err=1 until reset.
- Beat injected while IDLE → err=1, state stays IDLE, next burst completes normally.
- user_rst asserted mid-DATA (beat 2 of 8) → gnt, cmd_valid, busy go to 0 without waiting for a clock edge; after release, requester 0 wins a tie.
